// File: rtl/t05_hist_scan_pkg.sv
// Shared definitions for the histogram block: SRAM port encodings,
// histogram geometry and the scan state machine encoding.
package t05_pkg;

  localparam int HIST_BINS = 256;

  // wr_r_en encodings shared with the histogram writer; 2'd2 is never driven.
  localparam logic [1:0] SRAM_RD   = 2'd0;
  localparam logic [1:0] SRAM_WR   = 2'd1;
  localparam logic [1:0] SRAM_IDLE = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_EMIT  = 3'd3,
    S_CLEAR = 3'd4,
    S_NEXT  = 3'd5,
    S_DONE  = 3'd6
  } scan_state_e;

endpackage

// File: rtl/t05_hist_scan_if.sv
// (character, count) pair stream from the histogram scanner to the
// tree-building stage, valid/ready handshake.
interface t05_hist_scan_if;
  logic [7:0]  out_char;
  logic [31:0] out_count;
  logic        out_valid;
  logic        out_ready;

  modport master (output out_char, output out_count, output out_valid, input out_ready);
  modport slave  (input out_char, input out_count, input out_valid, output out_ready);
endinterface

// File: rtl/t05_hist_scan.sv
// Histogram read-back scanner: walks bins 0x00..0xFF, emits every non-zero
// bin as a (character, count) pair, optionally clears it, and cross-checks
// the summed counts against the writer's total.
module t05_hist_scan
  import t05_pkg::*;
#(
  parameter int RD_LAT        = 2,
  parameter bit CLEAR_ON_READ = 1'b1
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    start,
  input  logic [31:0]             total,
  input  logic [31:0]             sram_in,
  output logic [31:0]             sram_out,
  output logic [7:0]              hist_addr,
  output logic [1:0]              wr_r_en,
  t05_hist_scan_if.master         pair,
  output logic                    busy,
  output logic                    done,
  output logic [8:0]              sym_count,
  output logic                    mismatch
);

  // Index of the WAIT cycle on which read data is valid.
  localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

  scan_state_e state_r;
  scan_state_e state_s;
  logic [7:0]  addr_r;
  logic [31:0] count_r;
  logic [31:0] sum_r;
  logic [1:0]  wait_cnt_r;
  logic [8:0]  sym_count_r;
  logic        mismatch_r;
  logic [1:0]  wr_r_en_r;
  logic [1:0]  wr_r_en_s;
  logic        wait_last_s;
  logic        last_bin_s;

  // Next-state decode and the SRAM command that goes with the next state.
  always_comb begin
    state_s     = state_r;
    wr_r_en_s   = SRAM_IDLE;
    wait_last_s = (wait_cnt_r == WAIT_LAST);
    last_bin_s  = (addr_r == 8'hFF);
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s = S_REQ;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_REQ: begin
        state_s = S_WAIT;
      end
      S_WAIT: begin
        if (!wait_last_s) begin
          state_s = S_WAIT;
        end else if (sram_in == 32'd0) begin
          state_s = S_NEXT;
        end else begin
          state_s = S_EMIT;
        end
      end
      S_EMIT: begin
        if (!pair.out_ready) begin
          state_s = S_EMIT;
        end else if (CLEAR_ON_READ) begin
          state_s = S_CLEAR;
        end else begin
          state_s = S_NEXT;
        end
      end
      S_CLEAR: begin
        state_s = S_NEXT;
      end
      S_NEXT: begin
        if (last_bin_s) begin
          state_s = S_DONE;
        end else begin
          state_s = S_REQ;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
    // Registering the command from the next state lines it up with REQ/CLEAR.
    case (state_s)
      S_REQ:   wr_r_en_s = SRAM_RD;
      S_CLEAR: wr_r_en_s = SRAM_WR;
      default: wr_r_en_s = SRAM_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Scan datapath: address walk, read capture, running sum and result flags.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      addr_r      <= 8'd0;
      count_r     <= 32'd0;
      sum_r       <= 32'd0;
      wait_cnt_r  <= 2'd0;
      sym_count_r <= 9'd0;
      mismatch_r  <= 1'b0;
      wr_r_en_r   <= SRAM_IDLE;
    end else begin
      wr_r_en_r <= wr_r_en_s;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            addr_r      <= 8'd0;
            sum_r       <= 32'd0;
            sym_count_r <= 9'd0;
            mismatch_r  <= 1'b0;
          end
        end
        S_REQ: begin
          wait_cnt_r <= 2'd0;
        end
        S_WAIT: begin
          wait_cnt_r <= wait_cnt_r + 2'd1;
          if (wait_last_s) begin
            count_r <= sram_in;
          end
        end
        S_EMIT: begin
          if (pair.out_ready) begin
            sum_r       <= sum_r + count_r;
            sym_count_r <= sym_count_r + 9'd1;
          end
        end
        S_NEXT: begin
          // The sum is final here, so the flag is valid during the DONE cycle.
          if (last_bin_s) begin
            mismatch_r <= (sum_r != total);
          end else begin
            addr_r <= addr_r + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign hist_addr      = addr_r;
  assign wr_r_en        = wr_r_en_r;
  assign sram_out       = 32'd0;
  assign pair.out_char  = addr_r;
  assign pair.out_count = count_r;
  assign pair.out_valid = (state_r == S_EMIT);
  assign busy           = (state_r != S_IDLE);
  assign done           = (state_r == S_DONE);
  assign sym_count      = sym_count_r;
  assign mismatch       = mismatch_r;

endmodule

// File: doc/t05_hist_scan.md
# t05_hist_scan

Reads the completed character histogram back out of SRAM and hands every non-zero bin to the downstream tree-building stage. It is triggered once the histogram writer reaches end-of-file. It walks SRAM addresses 0x00–0xFF in ascending order, emits (character, count) pairs over a valid/ready handshake, and optionally clears each bin after reading it. It shares the histogram's SRAM port encoding and cross-checks the summed counts against the writer's `total`.

## Interface
Parameters:
- `RD_LAT`, default 2: cycles from a read-request cycle to valid `sram_in`; legal range 1–3.
- `CLEAR_ON_READ`, default 1: when 1, each non-zero bin is written back to 0 after it is emitted.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock, rising edge.
- `nrst` in 1: asynchronous active-low reset.
- `start` in 1: begin a scan; sampled only in IDLE; driven from histogram `eof`.
- `total` in 32: character total reported by the histogram writer.
- `sram_in` in 32: SRAM read data.
- `sram_out` out 32: SRAM write data; always 0 in this block.
- `hist_addr` out 8: SRAM address.
- `wr_r_en` out 2: 0 = read, 1 = write, 3 = idle; 2 is never driven.
- `out_char` out 8: character (bin address) of the current pair.
- `out_count` out 32: count of the current pair.
- `out_valid` out 1: pair is valid.
- `out_ready` in 1: downstream accepts the pair.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the scan finishes.
- `sym_count` out 9: number of non-zero bins emitted (0–256); held after `done`.
- `mismatch` out 1: set at `done` when the summed counts differ from `total`; held until the next `start`.

## Operation
States: IDLE, REQ, WAIT, EMIT, CLEAR, NEXT, DONE.

- **IDLE:** `wr_r_en` = 3.
  - On `start`: address ← 0, sum ← 0, `sym_count` ← 0, `mismatch` ← 0, then go to REQ.
  - `start` in any other state is ignored.
- **REQ:** `hist_addr` = address, `wr_r_en` = 0 for exactly one cycle, then go to WAIT.
- **WAIT:** `wr_r_en` = 3 for `RD_LAT` cycles.
  - On the last WAIT cycle, capture `sram_in` into the count register.
  - Count = 0: go to NEXT.
  - Count ≠ 0: go to EMIT.
- **EMIT:** `out_valid` = 1 with `out_char` = address and `out_count` = captured count.
  - Both values stay stable until `out_valid && out_ready`.
  - On the transfer: sum += count (32-bit, wraps mod 2^32) and `sym_count` += 1.
  - Then go to CLEAR if `CLEAR_ON_READ`, otherwise NEXT.
- **CLEAR:** `hist_addr` = address, `wr_r_en` = 1, `sram_out` = 0 for one cycle, then go to NEXT.
- **NEXT:**
  - Address = 0xFF: go to DONE. The 8-bit address never wraps back to 0 within a scan.
  - Otherwise: address += 1, go to REQ.
- **DONE:** `done` = 1 for one cycle, `mismatch` ← (sum ≠ `total`), then go to IDLE.

## Timing
- Reset values:
  - State = IDLE.
  - `wr_r_en` = 3.
  - `hist_addr`, `sram_out`, `out_char`, `out_count`, `out_valid`, `busy`, `done`, `sym_count`, `mismatch` = 0.
- Outputs are registered, except `out_valid`, `busy` and `done`, which decode from the state register.
- Cycles per bin:
  - Zero bin: 2 + `RD_LAT`.
  - Non-zero bin with `out_ready` held high: 3 + `RD_LAT` + `CLEAR_ON_READ`.
  - Every cycle `out_ready` is low in EMIT adds one cycle.
- `start` to first REQ: 1 cycle.
- `busy` is high from the cycle after `start` through the DONE cycle.
- While stalled in EMIT, no SRAM request is issued (`wr_r_en` = 3).
- `out_valid` is never withdrawn before the handshake completes.
- Reset mid-scan aborts immediately and issues no write. Any bin not yet cleared keeps its value.
- `start` coincident with `done` is ignored; the block must be in IDLE to accept `start`.

## Structure
- Shared package `t05_pkg` holds:
  - the `wr_r_en` encodings (`SRAM_RD`, `SRAM_WR`, `SRAM_IDLE`);
  - the scan state enum;
  - `HIST_BINS` = 256.
- The histogram writer adopts the same encodings from `t05_pkg`.
- No sub-module is needed. The WAIT counter is an inline 2-bit counter.

## Test plan
- **Reset:** assert `nrst` low mid-cycle → all outputs at their reset values asynchronously, `wr_r_en` = 3.
- **Normal scan:**
  - Stimulus: SRAM model with bin[0x1A] = 1, bin[0x61] = 3, bin[0x62] = 1, all others 0; `total` = 5; `out_ready` = 1; pulse `start`.
  - Response: pairs emitted in order (0x1A,1), (0x61,3), (0x62,1); `done` pulses once; `sym_count` = 3; `mismatch` = 0; all three bins read 0 afterwards.
- **Backpressure:** same data, `out_ready` held low for 5 cycles at the first EMIT → `out_char`/`out_count` stable throughout, no `wr_r_en` ≠ 3 during the stall, total scan 5 cycles longer.
- **Mismatch and no clear:** same data, `total` = 6, `CLEAR_ON_READ` = 0 → `mismatch` = 1 at `done`; SRAM contents unchanged; no write cycle ever observed.
- **Boundary bins:**
  - All 256 bins = 1 → 256 pairs, the last with `out_char` = 0xFF; `sym_count` = 256; no access to address 0 after 0xFF.
  - All bins = 0 → no `out_valid`; `done` after 256 × (2 + `RD_LAT`) + 2 cycles; `sym_count` = 0.
- **Reset mid-scan:** `nrst` low during WAIT at bin 0x61, then release and pulse `start` again → clean full rescan with the correct pairs.
